// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port block RAM among NREQ requesters.
// One op per cycle; response (read data or write ack) returns one cycle later.
module ram_port_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   ram_wren,
    output logic [ADDR_W-1:0]      ram_wraddr,
    output logic [DATA_W-1:0]      ram_di,
    output logic                   ram_rden,
    output logic [ADDR_W-1:0]      ram_rdaddr,
    input  logic [DATA_W-1:0]      ram_do
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     r_rsp_id;
    logic              r_rsp_pend;
    logic              r_rsp_is_rd;

    logic              w_found;
    logic              w_xfer;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_scan;
    logic [PW-1:0]     w_next_ptr;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    // Scan from the priority pointer, wrapping by explicit compare.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_scan  = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
            w_scan = (w_scan == LAST) ? '0 : w_scan + 1'b1;
        end
    end

    assign w_xfer     = w_found & ~rst;
    assign w_win_we   = req_we[w_win];
    assign w_win_addr = req_addr[w_win*ADDR_W +: ADDR_W];
    assign w_win_data = req_wdata[w_win*DATA_W +: DATA_W];
    assign w_next_ptr = (w_win == LAST) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready  = '0;
        ram_wren   = 1'b0;
        ram_wraddr = '0;
        ram_di     = '0;
        ram_rden   = 1'b0;
        ram_rdaddr = '0;
        if (w_xfer) begin
            req_ready[w_win] = 1'b1;
            if (w_win_we) begin
                ram_wren   = 1'b1;
                ram_wraddr = w_win_addr;
                ram_di     = w_win_data;
            end else begin
                ram_rden   = 1'b1;
                ram_rdaddr = w_win_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_id    <= '0;
            r_rsp_pend  <= 1'b0;
            r_rsp_is_rd <= 1'b0;
        end else begin
            r_rsp_pend <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr    <= w_next_ptr;
                r_rsp_id    <= w_win;
                r_rsp_is_rd <= ~w_win_we;
            end
        end
    end

    // Responses owed across a reset are dropped, hence the rst gate.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (r_rsp_pend && !rst) begin
            rsp_valid[r_rsp_id] = 1'b1;
            if (r_rsp_is_rd) rsp_rdata = ram_do;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, round-robin model,
// response scoreboard checked by a negedge monitor.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ram_wren;
    logic [9:0]  ram_wraddr;
    logic [15:0] ram_di;
    logic        ram_rden;
    logic [9:0]  ram_rdaddr;
    logic [15:0] ram_do = '0;

    ram_port_arbiter #(.NREQ(2), .ADDR_W(10), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .ram_di(ram_di),
        .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [1024];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_wraddr] <= ram_di;
        if (ram_rden) ram_do <= ram[ram_rdaddr];
    end

    typedef struct {
        logic [1:0]  v;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_mem [1024];
    int          m_ptr = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Monitor runs at negedge; tasks sample at negedge+1 so pops precede pushes.
    always @(negedge clk) begin
        exp_t e;
        e.v = 2'b00;
        e.d = 16'h0000;
        if (q.size() > 0) e = q.pop_front();
        n_cmp++;
        if (rsp_valid !== e.v) begin
            n_err++;
            $display("FAIL rsp_valid got=%b exp=%b t=%0t", rsp_valid, e.v, $time);
        end
        if (e.v != 2'b00) begin
            n_cmp++;
            if (rsp_rdata !== e.d) begin
                n_err++;
                $display("FAIL rsp_rdata got=%h exp=%h t=%0t", rsp_rdata, e.d, $time);
            end
        end
    end

    function automatic int model_win(logic [1:0] v);
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (m_ptr + k) % 2;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_accept(int w);
        exp_t e;
        logic [9:0] a;
        if (w < 0) return;
        a = req_addr[w*10 +: 10];
        e.v = 2'b01 << w;
        e.d = req_we[w] ? 16'h0000 : m_mem[a];
        if (req_we[w]) m_mem[a] = req_wdata[w*16 +: 16];
        q.push_back(e);
        m_ptr = (w + 1) % 2;
    endtask

    task automatic set_req(int i, bit v, bit we, logic [9:0] a, logic [15:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*10 +: 10] = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1, 0, 10'd1, 16'h0);
        set_req(1, 1, 1, 10'd2, 16'h5555);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (req_ready !== 2'b00 || ram_wren !== 1'b0 || ram_rden !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out rdy=%b wren=%b rden=%b exp=0", req_ready, ram_wren, ram_rden);
            end
            next_cycle();
        end
        req_valid = '0;
        rst = 1'b0;
        q.delete();
        m_ptr = 0;
    endtask

    task automatic test_write_read();
        int w;
        set_req(0, 1, 1, 10'd5, 16'hA5A5);
        @(negedge clk);
        #1;
        w = model_win(req_valid);
        n_cmp++;
        if (req_ready !== 2'b01 || ram_wren !== 1'b1 || ram_rden !== 1'b0 ||
            ram_wraddr !== 10'd5 || ram_di !== 16'hA5A5) begin
            n_err++;
            $display("FAIL wr_issue rdy=%b wren=%b rden=%b a=%0d d=%h exp 01 1 0 5 a5a5",
                     req_ready, ram_wren, ram_rden, ram_wraddr, ram_di);
        end
        model_accept(w);
        next_cycle();
        set_req(0, 1, 0, 10'd5, 16'h0);
        @(negedge clk);
        #1;
        w = model_win(req_valid);
        n_cmp++;
        if (req_ready !== 2'b01 || ram_rden !== 1'b1 || ram_wren !== 1'b0 ||
            ram_rdaddr !== 10'd5) begin
            n_err++;
            $display("FAIL rd_issue rdy=%b rden=%b wren=%b a=%0d exp 01 1 0 5",
                     req_ready, ram_rden, ram_wren, ram_rdaddr);
        end
        model_accept(w);
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_alternate_reads();
        int w;
        logic [1:0] exp_rdy;
        ram[0] = 16'h0001;
        ram[1] = 16'hAAAA;
        m_mem[0] = 16'h0001;
        m_mem[1] = 16'hAAAA;
        set_req(0, 1, 0, 10'd0, 16'h0);
        set_req(1, 1, 0, 10'd1, 16'h0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            w = model_win(req_valid);
            exp_rdy = 2'b01 << w;
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL alt_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            model_accept(w);
            next_cycle();
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_raw_hazard();
        int w;
        logic [1:0] exp_rdy;
        set_req(1, 1, 1, 10'd3, 16'h1234);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            w = model_win(req_valid);
            exp_rdy = (w < 0) ? 2'b00 : (2'b01 << w);
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL raw_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            model_accept(w);
            next_cycle();
            req_valid = '0;
            set_req(0, 1, 0, 10'd3, 16'h0);
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_reset_discard();
        int w;
        set_req(0, 1, 0, 10'd1, 16'h0);
        @(negedge clk);
        #1;
        w = model_win(req_valid);
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rst_pre_grant got=%b exp=01", req_ready);
        end
        next_cycle();
        rst = 1'b1;
        req_valid = '0;
        m_ptr = 0;
        next_cycle();
        rst = 1'b0;
        set_req(0, 1, 0, 10'd0, 16'h0);
        set_req(1, 1, 0, 10'd1, 16'h0);
        @(negedge clk);
        #1;
        w = model_win(req_valid);
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rst_post_grant got=%b exp=01", req_ready);
        end
        model_accept(w);
        next_cycle();
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_fairness();
        int w;
        int first;
        logic [1:0] exp_rdy;
        first = -1;
        set_req(0, 1, 0, 10'd0, 16'h0);
        set_req(1, 0, 0, 10'd1, 16'h0);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) req_valid[1] = 1'b1;
            @(negedge clk);
            #1;
            w = model_win(req_valid);
            exp_rdy = 2'b01 << w;
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
            end
            if (c >= 4 && first < 0 && req_ready[1]) first = c;
            model_accept(w);
            next_cycle();
        end
        n_cmp++;
        if (first < 0 || first > 5) begin
            n_err++;
            $display("FAIL fair_latency first_req1_grant=%0d exp<=5", first);
        end
        req_valid = '0;
        next_cycle();
    endtask

    task automatic test_idle();
        int w;
        logic [1:0] exp_rdy;
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (req_ready !== 2'b00 || ram_wren !== 1'b0 || ram_rden !== 1'b0) begin
                n_err++;
                $display("FAIL idle c=%0d rdy=%b wren=%b rden=%b exp=0",
                         c, req_ready, ram_wren, ram_rden);
            end
            next_cycle();
        end
        set_req(0, 1, 0, 10'd0, 16'h0);
        set_req(1, 1, 0, 10'd1, 16'h0);
        @(negedge clk);
        #1;
        w = model_win(req_valid);
        exp_rdy = 2'b01 << w;
        n_cmp++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL idle_ptr got=%b exp=%b", req_ready, exp_rdy);
        end
        model_accept(w);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate_reads();
        test_raw_hazard();
        test_reset_discard();
        test_fairness();
        test_idle();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
